// File: rtl/sd_fifo_pkg.sv
// Shared constants and helpers for the SD data-path FIFO.
package sd_fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_DEPTH_LOG2 = 8;

   // The count has one more bit than the pointers so it can hold 0..DEPTH.
   function automatic int items_width(input int depth_log2);
      return depth_log2 + 1;
   endfunction

endpackage

// File: rtl/sd_fifo_ram.sv
// Simple dual-port inferred memory for sd_fifo_param.
// Registered write; read is either asynchronous (show-ahead) or a
// read-enable registered output that clears to zero.
module sd_fifo_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int SHOW_AHEAD = 1
) (
   input  logic                  i_clk,
   input  logic                  i_clear,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];

   // Write port; memory contents are never cleared.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   generate
      if (SHOW_AHEAD != 0) begin : g_show_ahead
         // Read control is irrelevant when the head word is shown directly.
         logic w_unused_ctrl;
         assign w_unused_ctrl = i_clear | i_rd_en;
         assign o_rd_data     = r_mem[i_rd_addr];
      end else begin : g_registered
         logic [DATA_WIDTH-1:0] r_rd_data;
         // Output register loads only on an accepted pop and holds otherwise.
         always_ff @(posedge i_clk) begin
            if (i_clear)      r_rd_data <= '0;
            else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
         end
         assign o_rd_data = r_rd_data;
      end
   endgenerate

endmodule

// File: rtl/sd_fifo_param.sv
// Parametrised single-clock FIFO for the SD data path: pointer/count
// control, threshold flags and sticky under/overrun flags. Storage lives
// in sd_fifo_ram.
module sd_fifo_param
   import sd_fifo_pkg::*;
#(
   parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
   parameter int DEPTH_LOG2         = DEFAULT_DEPTH_LOG2,
   parameter int ALMOST_FULL_LEVEL  = (1 << DEPTH_LOG2) - 16,
   parameter int ALMOST_EMPTY_LEVEL = 16,
   parameter int SHOW_AHEAD         = 1
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_fifo_flush,
   input  logic                              i_fifo_push,
   input  logic                              i_fifo_pop,
   input  logic [DATA_WIDTH-1:0]             i_fifo_data,
   output logic [DATA_WIDTH-1:0]             o_fifo_data,
   output logic                              o_fifo_empty,
   output logic                              o_fifo_full,
   output logic                              o_fifo_almost_empty,
   output logic                              o_fifo_almost_full,
   output logic [items_width(DEPTH_LOG2)-1:0] o_fifo_items,
   output logic                              o_fifo_underrun,
   output logic                              o_fifo_overrun
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int IW    = items_width(DEPTH_LOG2);

   generate
      if (!(ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL && ALMOST_FULL_LEVEL <= DEPTH)) begin : g_bad_levels
         $error("sd_fifo_param: need ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
      end
   endgenerate

   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [IW-1:0]         r_items;
   logic                  r_underrun;
   logic                  r_overrun;

   logic w_clear;
   logic w_empty;
   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;

   // Flush behaves exactly like reset and discards any same-cycle request.
   assign w_clear   = i_reset | i_fifo_flush;
   assign w_empty   = (r_items == '0);
   assign w_full    = (r_items == IW'(DEPTH));
   assign w_pop_ok  = i_fifo_pop & ~w_empty & ~w_clear;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push_ok = i_fifo_push & (~w_full | w_pop_ok) & ~w_clear;

   // Pointer and count update.
   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_items  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_items <= r_items + IW'(w_push_ok) - IW'(w_pop_ok);
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (i_fifo_pop & w_empty)               r_underrun <= 1'b1;
         if (i_fifo_push & w_full & ~w_pop_ok)   r_overrun  <= 1'b1;
      end
   end

   sd_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_LOG2),
      .SHOW_AHEAD (SHOW_AHEAD)
   ) u_ram (
      .i_clk     (i_clk),
      .i_clear   (w_clear),
      .i_wr_en   (w_push_ok),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_fifo_data),
      .i_rd_en   (w_pop_ok),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (o_fifo_data)
   );

   assign o_fifo_items        = r_items;
   assign o_fifo_empty        = w_empty;
   assign o_fifo_full         = w_full;
   assign o_fifo_almost_full  = (int'(r_items) >= ALMOST_FULL_LEVEL);
   assign o_fifo_almost_empty = (int'(r_items) <= ALMOST_EMPTY_LEVEL);
   assign o_fifo_underrun     = r_underrun;
   assign o_fifo_overrun      = r_overrun;

endmodule

// File: tb/tb_sd_fifo_param.sv
// Bench for sd_fifo_param: a default show-ahead instance (32 x 256) and a
// registered-output instance (8 x 4), each compared against a queue model.
module tb_sd_fifo_param;

   localparam int DEPTH_A = 256;
   localparam int AF_A    = 240;
   localparam int AE_A    = 16;
   localparam int DEPTH_B = 4;
   localparam int AF_B    = 3;
   localparam int AE_B    = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A (defaults, show-ahead)
   logic        rst_a = 1'b1, flush_a = 1'b0, push_a = 1'b0, pop_a = 1'b0;
   logic [31:0] din_a = '0, dout_a;
   logic        empty_a, full_a, aempty_a, afull_a, under_a, over_a;
   logic [8:0]  items_a;

   // instance B (registered output, small)
   logic        rst_b = 1'b1, flush_b = 1'b0, push_b = 1'b0, pop_b = 1'b0;
   logic [7:0]  din_b = '0, dout_b;
   logic        empty_b, full_b, aempty_b, afull_b, under_b, over_b;
   logic [2:0]  items_b;

   sd_fifo_param dut_a (
      .i_clk(clk), .i_reset(rst_a), .i_fifo_flush(flush_a),
      .i_fifo_push(push_a), .i_fifo_pop(pop_a), .i_fifo_data(din_a),
      .o_fifo_data(dout_a), .o_fifo_empty(empty_a), .o_fifo_full(full_a),
      .o_fifo_almost_empty(aempty_a), .o_fifo_almost_full(afull_a),
      .o_fifo_items(items_a), .o_fifo_underrun(under_a), .o_fifo_overrun(over_a)
   );

   sd_fifo_param #(
      .DATA_WIDTH(8), .DEPTH_LOG2(2), .ALMOST_FULL_LEVEL(AF_B),
      .ALMOST_EMPTY_LEVEL(AE_B), .SHOW_AHEAD(0)
   ) dut_b (
      .i_clk(clk), .i_reset(rst_b), .i_fifo_flush(flush_b),
      .i_fifo_push(push_b), .i_fifo_pop(pop_b), .i_fifo_data(din_b),
      .o_fifo_data(dout_b), .o_fifo_empty(empty_b), .o_fifo_full(full_b),
      .o_fifo_almost_empty(aempty_b), .o_fifo_almost_full(afull_b),
      .o_fifo_items(items_b), .o_fifo_underrun(under_b), .o_fifo_overrun(over_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference models
   logic [31:0] q_a[$];
   bit          m_under_a, m_over_a;
   logic [7:0]  q_b[$];
   bit          m_under_b, m_over_b;
   logic [7:0]  m_dreg_b;

   // One clock of instance A: drive, check head before the edge, update model, check after.
   task automatic cyc_a(input bit rst, input bit fl, input bit push, input bit pop, input logic [31:0] d);
      bit pop_ok, push_ok;
      rst_a = rst; flush_a = fl; push_a = push; pop_a = pop; din_a = d;
      #1;
      if (!rst && !fl && pop && q_a.size() > 0) chk("a_head", dout_a, q_a[0]);
      @(posedge clk);
      if (rst || fl) begin
         q_a.delete(); m_under_a = 0; m_over_a = 0;
      end else begin
         pop_ok  = pop && q_a.size() > 0;
         push_ok = push && (q_a.size() < DEPTH_A || pop_ok);
         if (pop && !pop_ok)  m_under_a = 1;
         if (push && !push_ok) m_over_a = 1;
         if (pop_ok)  void'(q_a.pop_front());
         if (push_ok) q_a.push_back(d);
      end
      #1;
      chk("a_items",  items_a,  q_a.size());
      chk("a_empty",  empty_a,  q_a.size() == 0);
      chk("a_full",   full_a,   q_a.size() == DEPTH_A);
      chk("a_afull",  afull_a,  q_a.size() >= AF_A);
      chk("a_aempty", aempty_a, q_a.size() <= AE_A);
      chk("a_under",  under_a,  m_under_a);
      chk("a_over",   over_a,   m_over_a);
      @(negedge clk);
   endtask

   task automatic cyc_b(input bit rst, input bit fl, input bit push, input bit pop, input logic [7:0] d);
      bit pop_ok, push_ok;
      rst_b = rst; flush_b = fl; push_b = push; pop_b = pop; din_b = d;
      @(posedge clk);
      if (rst || fl) begin
         q_b.delete(); m_under_b = 0; m_over_b = 0; m_dreg_b = '0;
      end else begin
         pop_ok  = pop && q_b.size() > 0;
         push_ok = push && (q_b.size() < DEPTH_B || pop_ok);
         if (pop && !pop_ok)  m_under_b = 1;
         if (push && !push_ok) m_over_b = 1;
         if (pop_ok)  m_dreg_b = q_b.pop_front();
         if (push_ok) q_b.push_back(d);
      end
      #1;
      chk("b_data",   dout_b,   m_dreg_b);
      chk("b_items",  items_b,  q_b.size());
      chk("b_empty",  empty_b,  q_b.size() == 0);
      chk("b_full",   full_b,   q_b.size() == DEPTH_B);
      chk("b_afull",  afull_b,  q_b.size() >= AF_B);
      chk("b_aempty", aempty_b, q_b.size() <= AE_B);
      chk("b_under",  under_b,  m_under_b);
      chk("b_over",   over_b,   m_over_b);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // reset both instances together
      rst_b = 1'b1;
      cyc_a(1, 0, 0, 0, '0);
      cyc_a(1, 0, 1, 1, 32'hFFFF_FFFF);
      rst_b = 1'b0;
      cyc_b(1, 0, 0, 0, '0);

      // ---------------- instance A directed ----------------
      for (int i = 1; i <= 256; i++) cyc_a(0, 0, 1, 0, 32'(i));
      chk("a_full_after_fill", full_a, 1'b1);
      // full + push + pop: both accepted, no overrun
      cyc_a(0, 0, 1, 1, 32'h1234_5678);
      // rejected push on full
      cyc_a(0, 0, 1, 0, 32'hDEAD_BEEF);
      chk("a_overrun_set", over_a, 1'b1);
      // drain: 2..256 then 0x12345678
      for (int i = 0; i < 256; i++) cyc_a(0, 0, 0, 1, '0);
      chk("a_empty_after_drain", empty_a, 1'b1);
      cyc_a(0, 1, 0, 0, '0);
      // empty + push + pop: underrun, item stored
      cyc_a(0, 0, 1, 1, 32'hA5A5_A5A5);
      chk("a_underrun_set", under_a, 1'b1);
      cyc_a(0, 0, 0, 1, '0);
      // items = 100 with overrun, then flush with push
      cyc_a(0, 1, 0, 0, '0);
      for (int i = 0; i < 257; i++) cyc_a(0, 0, 1, 0, 32'h100 + 32'(i));
      for (int i = 0; i < 156; i++) cyc_a(0, 0, 0, 1, '0);
      chk("a_items_100", items_a, 32'd100);
      cyc_a(0, 1, 1, 0, 32'hCAFE_F00D);
      chk("a_flush_items", items_a, 32'd0);
      cyc_a(0, 0, 1, 0, 32'h0BAD_0001);
      cyc_a(0, 0, 0, 1, '0);

      // ---------------- instance A random ----------------
      for (int i = 0; i < 3000; i++) begin
         int mode = (i / 500) % 3;      // vary push/pop bias
         bit ps = ($urandom_range(99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50)));
         bit pp = ($urandom_range(99) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50)));
         bit fl = ($urandom_range(199) == 0);
         bit rs = ($urandom_range(499) == 0);
         cyc_a(rs, fl, ps, pp, $urandom);
      end

      // ---------------- instance B directed ----------------
      cyc_b(0, 0, 1, 0, 8'h11);
      cyc_b(0, 0, 1, 0, 8'h22);
      cyc_b(0, 0, 0, 1, '0);
      chk("b_first_pop", dout_b, 8'h11);
      cyc_b(0, 0, 0, 0, '0);
      cyc_b(0, 0, 0, 0, '0);
      chk("b_hold", dout_b, 8'h11);
      cyc_b(0, 0, 0, 1, '0);
      cyc_b(0, 0, 0, 1, '0);
      chk("b_hold_on_underrun", dout_b, 8'h22);
      for (int i = 0; i < 5; i++) cyc_b(0, 0, 1, 0, 8'h30 + 8'(i));
      cyc_b(0, 0, 1, 1, 8'h77);
      cyc_b(0, 1, 1, 1, 8'h88);
      chk("b_flush_data", dout_b, 8'h00);

      // ---------------- instance B random ----------------
      for (int i = 0; i < 2000; i++) begin
         bit ps = ($urandom_range(99) < 55);
         bit pp = ($urandom_range(99) < 45);
         bit fl = ($urandom_range(149) == 0);
         bit rs = ($urandom_range(299) == 0);
         cyc_b(rs, fl, ps, pp, 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
